ctrl_ram_saida: RTL and testbench

Sequencer that owns the write port of the output display RAM (3 seven-segment digits at row LINHA, columns COL_BASE..COL_BASE+2).

---
 rtl/ctrl_ram_saida_pkg.sv | 21 ++
 rtl/ctrl_ram_saida_if.sv | 22 ++
 rtl/ctrl_ram_saida_decod_7seg.sv | 9 +
 rtl/ctrl_ram_saida.sv | 102 ++++++++++
 tb/tb_ctrl_ram_saida.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_ram_saida_pkg.sv
// pkg_saida: shared patterns, state encoding and the double-dabble step used by ctrl_ram_saida
package pkg_saida;
    localparam int NUM_DIGITOS = 3;
    localparam int LARG_BCD = 4 * NUM_DIGITOS;
    localparam int LARG_DD = LARG_BCD + 10;
    localparam logic [6:0] PADRAO_APAGADO = 7'b1111110;
    localparam logic [6:0] PADRAO_E = 7'b0110000;
    localparam logic [9:0][6:0] TABELA_7SEG = {
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };
    typedef enum logic [2:0] {IDLE, CONV, ESC0, ESC1, ESC2, FIM} estado_t;
    // One iteration: BCD nibbles >= 5 get +3, then the whole {bcd, bin} word shifts left
    function automatic logic [LARG_DD-1:0] dd_passo(input logic [LARG_DD-1:0] v);
        logic [LARG_DD-1:0] a;
        a = v;
        for (int i = 0; i < NUM_DIGITOS; i++)
            if (a[10+4*i +: 4] >= 4'd5) a[10+4*i +: 4] = a[10+4*i +: 4] + 4'd3;
        return {a[LARG_DD-2:0], 1'b0};
    endfunction
endpackage

// File: rtl/ctrl_ram_saida_if.sv
// ctrl_ram_saida_if: CPU/clear request handshakes plus the display RAM write port
interface ctrl_ram_saida_if;
    logic       cpu_req;
    logic [9:0] cpu_valor;
    logic       clr_req;
    logic       cpu_ack;
    logic       clr_ack;
    logic       busy;
    logic       done;
    logic [6:0] data;
    logic [10:0] end_linha;
    logic [10:0] end_coluna;
    logic       write;
    modport master (
        output cpu_req, cpu_valor, clr_req,
        input  cpu_ack, clr_ack, busy, done, data, end_linha, end_coluna, write
    );
    modport slave (
        input  cpu_req, cpu_valor, clr_req,
        output cpu_ack, clr_ack, busy, done, data, end_linha, end_coluna, write
    );
endinterface

// File: rtl/ctrl_ram_saida_decod_7seg.sv
// decod_7seg: BCD digit to active-low seven-segment pattern, non-decimal codes blank
module decod_7seg
    import pkg_saida::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    assign o_seg = (i_bcd > 4'd9) ? PADRAO_APAGADO : TABELA_7SEG[i_bcd];
endmodule

// File: rtl/ctrl_ram_saida.sv
// ctrl_ram_saida: arbitrates print/clear requests and writes three 7-seg digits to the display RAM
module ctrl_ram_saida
    import pkg_saida::*;
#(
    parameter int LINHA = 0,
    parameter int COL_BASE = 0,
    parameter int SUPRIME_ZEROS = 0
) (
    input logic             clock,
    input logic             resetCPU,
    ctrl_ram_saida_if.slave io
);
    localparam logic SUPR = (SUPRIME_ZEROS != 0);
    estado_t r_estado;
    estado_t w_prox;
    logic [3:0] r_iter;
    logic [LARG_DD-1:0] r_shift;
    logic [9:0] r_valor;
    logic r_limpa;
    logic [6:0] r_data;
    logic w_cpu_ack;
    logic w_clr_ack;
    logic w_write;
    logic [1:0] w_off;
    logic [3:0] w_cent;
    logic [3:0] w_dez;
    logic [3:0] w_uni;
    logic [3:0] w_digito;
    logic [6:0] w_seg;
    logic [6:0] w_padrao;
    logic w_ovf;
    logic w_apaga;
    always_ff @(posedge clock) begin
        if (resetCPU) begin
            r_estado <= IDLE;
            r_iter <= 4'd0;
            r_shift <= '0;
            r_valor <= 10'd0;
            r_limpa <= 1'b0;
            r_data <= PADRAO_APAGADO;
        end else begin
            r_estado <= w_prox;
            if (w_clr_ack) begin
                r_limpa <= 1'b1;
            end else if (w_cpu_ack) begin
                r_limpa <= 1'b0;
                r_valor <= io.cpu_valor;
                r_shift <= {{LARG_BCD{1'b0}}, io.cpu_valor};
                r_iter <= 4'd0;
            end else if (r_estado == CONV) begin
                r_shift <= dd_passo(r_shift);
                r_iter <= r_iter + 4'd1;
            end
            if (w_write) r_data <= w_padrao;
        end
    end
    // Clear has fixed priority; requests are only looked at in IDLE
    always_comb begin
        w_prox = r_estado;
        w_cpu_ack = 1'b0;
        w_clr_ack = 1'b0;
        w_off = 2'd0;
        case (r_estado)
            IDLE: begin
                w_clr_ack = io.clr_req & ~resetCPU;
                w_cpu_ack = io.cpu_req & ~io.clr_req & ~resetCPU;
                w_prox = io.clr_req ? ESC0 : io.cpu_req ? CONV : IDLE;
            end
            CONV: w_prox = (r_iter == 4'd9) ? ESC0 : CONV;
            ESC0: w_prox = ESC1;
            ESC1: begin
                w_prox = ESC2;
                w_off = 2'd1;
            end
            ESC2: begin
                w_prox = FIM;
                w_off = 2'd2;
            end
            default: w_prox = IDLE;
        endcase
    end
    assign w_write = (r_estado == ESC0) || (r_estado == ESC1) || (r_estado == ESC2);
    assign w_cent = r_shift[LARG_DD-1 -: 4];
    assign w_dez = r_shift[LARG_DD-5 -: 4];
    assign w_uni = r_shift[LARG_DD-9 -: 4];
    assign w_digito = (r_estado == ESC0) ? w_cent : (r_estado == ESC1) ? w_dez : w_uni;
    assign w_ovf = r_valor > 10'd999;
    assign w_apaga = SUPR && (w_cent == 4'd0) && ((r_estado == ESC0) || ((r_estado == ESC1) && (w_dez == 4'd0)));
    decod_7seg u_decod (
        .i_bcd(w_digito),
        .o_seg(w_seg)
    );
    assign w_padrao = r_limpa ? PADRAO_APAGADO : w_ovf ? PADRAO_E : w_apaga ? PADRAO_APAGADO : w_seg;
    assign io.cpu_ack = w_cpu_ack;
    assign io.clr_ack = w_clr_ack;
    assign io.busy = (r_estado == CONV) || w_write;
    assign io.done = (r_estado == FIM);
    assign io.write = w_write;
    assign io.data = w_write ? w_padrao : r_data;
    assign io.end_linha = 11'(LINHA);
    assign io.end_coluna = 11'(COL_BASE) + {9'd0, w_off};
endmodule

// File: tb/tb_ctrl_ram_saida.sv
// tb_ctrl_ram_saida: directed sequence with a write scoreboard on two instances (zero suppression off/on)
module tb_ctrl_ram_saida;
    typedef struct {
        logic [10:0] col;
        logic [6:0]  dat;
    } esc_t;
    localparam int COL_A = 8;
    localparam int LIN_A = 5;
    localparam logic [6:0] BLANK = 7'b1111110;
    localparam logic [6:0] LETRA_E = 7'b0110000;
    logic clock = 1'b0;
    logic resetCPU = 1'b1;
    logic cpu_req = 1'b0;
    logic clr_req = 1'b0;
    logic [9:0] cpu_valor = 10'd0;
    int total = 0;
    int bad = 0;
    esc_t q_a[$];
    esc_t q_z[$];
    ctrl_ram_saida_if a_if ();
    ctrl_ram_saida_if z_if ();
    assign a_if.cpu_req = cpu_req;
    assign a_if.clr_req = clr_req;
    assign a_if.cpu_valor = cpu_valor;
    assign z_if.cpu_req = cpu_req;
    assign z_if.clr_req = clr_req;
    assign z_if.cpu_valor = cpu_valor;
    ctrl_ram_saida #(.LINHA(LIN_A), .COL_BASE(COL_A), .SUPRIME_ZEROS(0)) dut (
        .clock(clock), .resetCPU(resetCPU), .io(a_if)
    );
    ctrl_ram_saida #(.LINHA(0), .COL_BASE(0), .SUPRIME_ZEROS(1)) dut_z (
        .clock(clock), .resetCPU(resetCPU), .io(z_if)
    );
    always #5 clock = ~clock;
    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return BLANK;
        endcase
    endfunction
    task automatic push_cpu(input int v, input int n);
        int dg[3];
        logic [6:0] pa;
        logic [6:0] pz;
        dg[0] = v / 100;
        dg[1] = (v / 10) % 10;
        dg[2] = v % 10;
        for (int i = 0; i < n; i++) begin
            pa = (v > 999) ? LETRA_E : seg(dg[i]);
            pz = pa;
            if (v <= 999 && ((i == 0 && dg[0] == 0) || (i == 1 && dg[0] == 0 && dg[1] == 0))) pz = BLANK;
            q_a.push_back('{11'(COL_A + i), pa});
            q_z.push_back('{11'(i), pz});
        end
    endtask
    task automatic push_clr();
        for (int i = 0; i < 3; i++) begin
            q_a.push_back('{11'(COL_A + i), BLANK});
            q_z.push_back('{11'(i), BLANK});
        end
    endtask
    task automatic espera(input int w0);
        for (int k = 1; k <= w0 + 3; k++) begin
            @(negedge clock);
            chk($sformatf("busy_c%0d", k), a_if.busy, 32'(k <= w0 + 2));
            chk($sformatf("write_c%0d", k), a_if.write, 32'(k >= w0 && k <= w0 + 2));
            chk($sformatf("done_c%0d", k), a_if.done, 32'(k == w0 + 3));
            chk($sformatf("acks_c%0d", k), {a_if.cpu_ack, a_if.clr_ack}, 0);
        end
    endtask
    task automatic cpu(input int v, input logic manter);
        push_cpu(v, 3);
        cpu_valor = 10'(v);
        cpu_req = 1'b1;
        @(negedge clock);
        chk($sformatf("cpu_ack_%0d", v), a_if.cpu_ack, 1);
        chk("clr_ack_idle", a_if.clr_ack, 0);
        chk("busy_accept", a_if.busy, 0);
        @(posedge clock);
        #1;
        cpu_req = manter;
        cpu_valor = ~10'(v);
        espera(11);
        @(posedge clock);
        #1;
    endtask
    always @(negedge clock) begin : mon_a
        esc_t e;
        if (a_if.write === 1'b1) begin
            total++;
            assert (q_a.size() != 0) else begin
                bad++;
                $error("FAIL sb_a_unexpected obs=write col=%0d exp=no write", a_if.end_coluna);
            end
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk("sb_a_col", a_if.end_coluna, e.col);
                chk("sb_a_dat", a_if.data, e.dat);
            end
        end
    end
    always @(negedge clock) begin : mon_z
        esc_t e;
        if (z_if.write === 1'b1) begin
            total++;
            assert (q_z.size() != 0) else begin
                bad++;
                $error("FAIL sb_z_unexpected obs=write col=%0d exp=no write", z_if.end_coluna);
            end
            if (q_z.size() != 0) begin
                e = q_z.pop_front();
                chk("sb_z_col", z_if.end_coluna, e.col);
                chk("sb_z_dat", z_if.data, e.dat);
            end
        end
    end
    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", a_if.busy, 0);
        chk("rst_done", a_if.done, 0);
        chk("rst_write", a_if.write, 0);
        chk("rst_acks", {a_if.cpu_ack, a_if.clr_ack}, 0);
        chk("rst_data_a", a_if.data, BLANK);
        chk("rst_data_z", z_if.data, BLANK);
        chk("rst_col_a", a_if.end_coluna, COL_A);
        chk("rst_col_z", z_if.end_coluna, 0);
        chk("lin_a", a_if.end_linha, LIN_A);
        chk("lin_z", z_if.end_linha, 0);
        @(posedge clock);
        #1;
        resetCPU = 1'b0;
        cpu(123, 1'b1);
        cpu(7, 1'b0);
        cpu(1000, 1'b0);
        cpu(1023, 1'b0);
        cpu(999, 1'b0);
        push_clr();
        push_cpu(45, 3);
        clr_req = 1'b1;
        cpu_req = 1'b1;
        cpu_valor = 10'd45;
        @(negedge clock);
        chk("both_clr_ack", a_if.clr_ack, 1);
        chk("both_cpu_ack", a_if.cpu_ack, 0);
        @(posedge clock);
        #1;
        clr_req = 1'b0;
        espera(1);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("cpu_ack_after_clr", a_if.cpu_ack, 1);
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
        cpu_valor = 10'd0;
        espera(11);
        @(posedge clock);
        #1;
        push_cpu(456, 2);
        cpu_valor = 10'd456;
        cpu_req = 1'b1;
        @(negedge clock);
        chk("cpu_ack_456", a_if.cpu_ack, 1);
        @(posedge clock);
        #1;
        repeat (11) @(posedge clock);
        #1;
        resetCPU = 1'b1;
        @(negedge clock);
        chk("write_in_rst_cycle", a_if.write, 1);
        @(posedge clock);
        #1;
        resetCPU = 1'b0;
        push_cpu(88, 3);
        cpu_valor = 10'd88;
        @(negedge clock);
        chk("post_rst_write", a_if.write, 0);
        chk("post_rst_busy", a_if.busy, 0);
        chk("post_rst_done", a_if.done, 0);
        chk("post_rst_data", a_if.data, BLANK);
        chk("post_rst_col", a_if.end_coluna, COL_A);
        chk("post_rst_cpu_ack", a_if.cpu_ack, 1);
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
        espera(11);
        @(posedge clock);
        #1;
        push_clr();
        clr_req = 1'b1;
        @(negedge clock);
        chk("clr_ack", a_if.clr_ack, 1);
        @(posedge clock);
        #1;
        clr_req = 1'b0;
        espera(1);
        repeat (3) @(negedge clock);
        chk("idle_write", a_if.write, 0);
        chk("idle_data_hold", a_if.data, BLANK);
        chk("sb_a_left", q_a.size(), 0);
        chk("sb_z_left", q_z.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
